// File: rtl/ham_serial_tx_if.sv
// Codeword handshake between the Hamming (7,4) encoder and the serial transmitter.
interface ham_serial_tx_if;
    logic [6:0] c;
    logic       c_valid;
    logic       c_ready;

    modport master (output c, output c_valid, input c_ready);
    modport slave  (input c, input c_valid, output c_ready);
endinterface

// File: rtl/ham_serial_tx.sv
// Serial frame transmitter for 7-bit Hamming codewords: start bit, 7 data bits LSB first,
// stop bit, with a one-deep holding register so frames can run back-to-back.
module ham_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ham_serial_tx_if.slave    cif,
    output logic              tx,
    output logic              busy,
    output logic [7:0]        frame_cnt
);
    localparam int unsigned      BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e             state_q, state_d;
    logic [6:0]         hold_q, hold_d;
    logic               hold_vld_q, hold_vld_d;
    logic [6:0]         shift_q, shift_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         idx_q, idx_d;
    logic               tx_q, tx_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               accept;
    logic               bit_end;

    assign cif.c_ready = !hold_vld_q;
    assign accept      = cif.c_valid && !hold_vld_q;
    assign bit_end     = (baud_q == BAUD_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        shift_d     = shift_q;
        baud_d      = baud_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;

        // Accept only happens with hold empty, so it never collides with a drain below.
        if (accept) begin
            hold_d     = cif.c;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_vld_q) begin
                    shift_d    = hold_q;
                    hold_vld_d = 1'b0;
                    baud_d     = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd6) state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d      = '0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (hold_vld_q) begin
                        shift_d    = hold_q;
                        hold_vld_d = 1'b0;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase

        // Line level follows the state being entered so tx only moves at bit boundaries.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            shift_q     <= '0;
            baud_q      <= '0;
            idx_q       <= '0;
            tx_q        <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            shift_q     <= shift_d;
            baud_q      <= baud_d;
            idx_q       <= idx_d;
            tx_q        <= tx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_ham_serial_tx.sv
// Bench for ham_serial_tx at CLKS_PER_BIT 4, 2 and 1; a line receiver per instance
// rebuilds each frame and compares it against a queue of expected codewords.
module tb_ham_serial_tx;
    logic       clk;
    logic       rst_n;
    logic [6:0] drv_c  [3];
    logic       drv_v  [3];
    logic       rdy    [3];
    logic       tx_w   [3];
    logic       busy_w [3];
    logic [7:0] cnt_w  [3];

    logic [6:0] exp_q [3][$];
    int started  [3];
    int done     [3];
    int last_gap [3];
    int idle_run [3];

    int checks;
    int errors;
    int cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int CPB = (g == 0) ? 4 : (g == 1) ? 2 : 1;

        ham_serial_tx_if ifc ();
        assign ifc.c       = drv_c[g];
        assign ifc.c_valid = drv_v[g];
        assign rdy[g]      = ifc.c_ready;

        ham_serial_tx #(.CLKS_PER_BIT(CPB)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cif       (ifc.slave),
            .tx        (tx_w[g]),
            .busy      (busy_w[g]),
            .frame_cnt (cnt_w[g])
        );

        initial begin : mon
            int         t;
            int         b;
            logic       active;
            logic       have_exp;
            logic       stable;
            logic       busy_ok;
            logic [6:0] e;
            logic [8:0] exp_f;
            logic [8:0] act_f;
            active = 1'b0;
            t = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    active      = 1'b0;
                    idle_run[g] = 0;
                end else if (!active && tx_w[g] === 1'b0) begin
                    active      = 1'b1;
                    t           = 0;
                    stable      = 1'b1;
                    busy_ok     = 1'b1;
                    act_f       = '0;
                    started[g]++;
                    last_gap[g] = idle_run[g];
                    idle_run[g] = 0;
                    have_exp    = (exp_q[g].size() > 0);
                    if (have_exp) begin
                        e     = exp_q[g].pop_front();
                        exp_f = {1'b1, e, 1'b0};
                    end else begin
                        exp_f = '0;
                    end
                end else if (!active) begin
                    idle_run[g]++;
                end

                if (active && rst_n) begin
                    b = t / CPB;
                    if (t % CPB == 0) act_f[b] = tx_w[g];
                    else if (tx_w[g] !== act_f[b]) stable = 1'b0;
                    if (busy_w[g] !== 1'b1) busy_ok = 1'b0;
                    if (t == 9 * CPB - 1) begin
                        check($sformatf("frame_g%0d_n%0d", g, done[g]),
                              {20'd0, have_exp, busy_ok, stable, act_f},
                              {20'd0, 3'b111, exp_f});
                        done[g]++;
                        active = 1'b0;
                    end else begin
                        t++;
                    end
                end
            end
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Caller sits at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int g, input logic [6:0] v, output int acc_cyc);
        int n;
        drv_c[g] = v;
        drv_v[g] = 1'b1;
        exp_q[g].push_back(v);
        n = 0;
        while (!rdy[g] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_timeout_g%0d", g), (n >= 400) ? 32'd1 : 32'd0, 32'd0);
        @(negedge clk);
        acc_cyc  = cyc;
        drv_v[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int budget);
        logic ok;
        ok = 1'b0;
        repeat (budget) begin
            @(negedge clk);
            if (!busy_w[g] && rdy[g]) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("idle_reached_g%0d", g), {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int n;
        int bad;
        int a1;
        int a2;
        int s0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int g = 0; g < 3; g++) begin
            drv_c[g]    = '0;
            drv_v[g]    = 1'b0;
            started[g]  = 0;
            done[g]     = 0;
            last_gap[g] = 0;
            idle_run[g] = 0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset_tx_g%0d", g),   {31'd0, tx_w[g]},   32'd1);
            check($sformatf("reset_busy_g%0d", g), {31'd0, busy_w[g]}, 32'd0);
            check($sformatf("reset_rdy_g%0d", g),  {31'd0, rdy[g]},    32'd1);
            check($sformatf("reset_cnt_g%0d", g),  {24'd0, cnt_w[g]},  32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame at 4 clocks per bit.
        send(0, 7'b1010101, a1);
        check("single_rdy_after_accept", {31'd0, rdy[0]},    32'd0);
        check("single_busy_before",      {31'd0, busy_w[0]}, 32'd0);
        @(negedge clk);
        check("single_start_tx",   {31'd0, tx_w[0]},   32'd0);
        check("single_start_busy", {31'd0, busy_w[0]}, 32'd1);
        check("single_start_rdy",  {31'd0, rdy[0]},    32'd1);
        n = 1;
        repeat (200) begin
            @(negedge clk);
            if (!busy_w[0]) break;
            n++;
        end
        check("single_busy_cycles", n, 32'd36);
        check("single_frame_cnt",   {24'd0, cnt_w[0]}, 32'd1);
        check("single_tx_after",    {31'd0, tx_w[0]},  32'd1);

        // Idle gap.
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rdy[0] !== 1'b1) bad++;
        end
        check("idle_gap_bad_cycles", bad, 32'd0);

        // Backpressure: shift and hold both occupied, then 0x2A waits.
        send(0, 7'h11, a1);
        send(0, 7'h22, a1);
        drv_c[0] = 7'h2A;
        drv_v[0] = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rdy[0]) bad++;
        end
        check("bp_early_accepts", bad, 32'd0);
        send(0, 7'h2A, a1);
        wait_idle(0, 300);
        check("bp_frame_cnt", {24'd0, cnt_w[0]}, 32'd4);

        // Reset in the middle of a data bit with a codeword buffered.
        send(0, 7'h55, a1);
        send(0, 7'h33, a1);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_tx",   {31'd0, tx_w[0]},   32'd1);
        check("rst_mid_busy", {31'd0, busy_w[0]}, 32'd0);
        check("rst_mid_rdy",  {31'd0, rdy[0]},    32'd1);
        check("rst_mid_cnt",  {24'd0, cnt_w[0]},  32'd0);
        exp_q[0].delete();
        s0 = started[0];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_no_new_frame", started[0] - s0, 32'd0);
        check("rst_cnt_after",    {24'd0, cnt_w[0]}, 32'd0);

        // Back-to-back at 2 clocks per bit.
        send(1, 7'h0F, a1);
        check("b2b_rdy_drop", {31'd0, rdy[1]}, 32'd0);
        send(1, 7'h70, a2);
        check("b2b_accept_spacing", a2 - a1, 32'd2);
        wait_idle(1, 100);
        check("b2b_gap",       last_gap[1], 32'd0);
        check("b2b_frames",    done[1], 32'd2);
        check("b2b_frame_cnt", {24'd0, cnt_w[1]}, 32'd2);

        // 256 all-zero frames at 1 clock per bit wrap the frame counter.
        for (int i = 0; i < 256; i++) send(2, 7'h00, a1);
        wait_idle(2, 100);
        check("wrap_frames",    done[2], 32'd256);
        check("wrap_frame_cnt", {24'd0, cnt_w[2]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
